instr_decode: RTL

//  Instruction queue + decoder directly downstream of the instruction fetcher.

---
 rtl/tproc_isa_pkg.sv | 38 +++
 rtl/instr_sync_fifo.sv | 58 +++++
 rtl/instr_decode.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/tproc_isa_pkg.sv
// Instruction-set constants, instruction word layout and decode FSM states shared by the
// instruction queue/decoder.
package tproc_isa_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LOAD = 8'h04;
  localparam logic [7:0] OP_CONV = 8'h81;
  localparam logic [7:0] OP_END  = 8'hFF;

  localparam int unsigned OPCODE_LSB = 56;
  localparam int unsigned FTYPE_LSB  = 48;
  localparam int unsigned SADDR_LSB  = 32;
  localparam int unsigned DADDR_LSB  = 16;
  localparam int unsigned MEMSEL_LSB = 8;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  ftype;
    logic [15:0] saddr;
    logic [15:0] daddr;
    logic [7:0]  memsel;
    logic [7:0]  unused;
  } instr_t;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StIssue,
    StWait,
    StDone
  } dec_state_e;

  function automatic logic is_known_op(input logic [7:0] op);
    return (op == OP_NOP) || (op == OP_LOAD) || (op == OP_CONV) || (op == OP_END);
  endfunction

endpackage

// File: rtl/instr_sync_fifo.sv
// Synchronous instruction FIFO: power-of-two depth, writes while full are dropped and
// flagged, reads while empty are ignored.
module instr_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             wr_drop
);

  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_wr, do_rd;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign wr_drop = wr_en & full;
  assign rd_data = mem[rd_ptr_q];

  // Storage is not reset; pointer reset alone flushes the queue.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_decode.sv
// Instruction queue + in-order decoder dispatching LOAD/CONV over valid/ready, one command
// in flight. Define DECODE_ERR_CNT_EN to add the saturating err_cnt output.
module instr_decode
  import tproc_isa_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] in_instr,
  input  logic        in_instr_valid,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        fetcher_enable,
  output logic [7:0]  op_ftype,
  output logic [15:0] op_saddr,
  output logic [15:0] op_daddr,
  output logic [7:0]  op_memsel,
  output logic        ld_valid,
  input  logic        ld_ready,
  input  logic        ld_done,
  output logic        cv_valid,
  input  logic        cv_ready,
  input  logic        cv_done,
  output logic        busy,
  output logic        prog_done,
  output logic        illegal_instr
`ifdef DECODE_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  dec_state_e       state_q, state_d;
  instr_t           instr_q;
  logic [63:0]      fifo_rdata;
  logic             fifo_pop, fifo_drop;
  logic [FIFO_AW:0] fifo_count_unused;
  logic [7:0]       instr_unused;
  logic             is_load, is_conv;

  assign fifo_pop = (state_q == StFetch) && !fifo_empty;

  instr_sync_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_instr_valid),
    .wr_data (in_instr),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_unused),
    .wr_drop (fifo_drop)
  );

  // instr_q only changes on a pop, so op_* stay stable through ISSUE and WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
    end else if (fifo_pop) begin
      instr_q <= instr_t'(fifo_rdata);
    end
  end

  assign is_load      = (instr_q.opcode == OP_LOAD);
  assign is_conv      = (instr_q.opcode == OP_CONV);
  assign op_ftype     = instr_q.ftype;
  assign op_saddr     = instr_q.saddr;
  assign op_daddr     = instr_q.daddr;
  assign op_memsel    = instr_q.memsel;
  assign instr_unused = instr_q.unused;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        if (!fifo_empty) state_d = StDecode;
      end
      StDecode: begin
        unique case (instr_q.opcode)
          OP_LOAD, OP_CONV: state_d = StIssue;
          OP_END:           state_d = StDone;
          default:          state_d = StFetch;
        endcase
      end
      StIssue: begin
        if ((is_load && ld_ready) || (is_conv && cv_ready)) state_d = StWait;
      end
      StWait: begin
        // Only the done of the unit that owns the command retires it.
        if ((is_load && ld_done) || (is_conv && cv_done)) state_d = StFetch;
      end
      StDone: begin
        if (start) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ld_valid      = 1'b0;
    cv_valid      = 1'b0;
    illegal_instr = 1'b0;
    prog_done     = 1'b0;
    unique case (state_q)
      StIssue: begin
        ld_valid = is_load;
        cv_valid = is_conv;
      end
      StDecode: illegal_instr = !is_known_op(instr_q.opcode);
      StDone:   prog_done = 1'b1;
      default: ;
    endcase
    busy           = (state_q != StIdle) && (state_q != StDone);
    fetcher_enable = busy;
  end

`ifdef DECODE_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  // An illegal decode and an overflow drop can land in the same cycle.
  always_comb begin
    err_inc = {1'b0, illegal_instr} + {1'b0, fifo_drop};
    err_sum = {1'b0, err_cnt_q} + {15'b0, err_inc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic drop_unused;
  assign drop_unused = fifo_drop;
`endif

endmodule
